// File: rtl/tdm_defs.sv
// Shared TDM framing constants, used by both the mux-side transmitter and
// the demux-side receiver.
package tdm_defs;

  // Receiver framing states (1-bit encoding).
  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Slots per frame and width of the slot index.
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/demux_1x4.sv
// Gate-level 2-to-4 one-hot decoder with enable. It turns the slot index
// into per-slot write enables; all outputs are low when en is low.
module demux_1x4
  import tdm_defs::*;
(
  input  logic [SLOT_W-1:0] sel,
  input  logic              en,
  output logic [SLOTS-1:0]  we
);

  logic sel0_n;
  logic sel1_n;

  assign sel0_n = ~sel[0];
  assign sel1_n = ~sel[1];

  assign we[0] = en & sel1_n & sel0_n;
  assign we[1] = en & sel1_n & sel[0];
  assign we[2] = en & sel[1] & sel0_n;
  assign we[3] = en & sel[1] & sel[0];

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-slot TDM receiver. Locks to frame_sync, gathers one frame of beats into
// shadow registers and publishes all four channels at once with a strobe.
module tdm_demux_4ch
  import tdm_defs::*;
#(
  parameter int WIDTH  = 1,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic [0:0]        state;
  logic [SLOT_W-1:0] slot;
  logic [WIDTH-1:0]  shadow0;
  logic [WIDTH-1:0]  shadow1;
  logic [WIDTH-1:0]  shadow2;

  logic [SLOT_W-1:0] wr_sel;
  logic              wr_en;
  logic [SLOTS-1:0]  wr_we;
  logic              in_frame;

  // A sync beat always lands in slot 0; otherwise only a locked receiver
  // that is mid-frame accepts the beat into the current slot. we[3] is the
  // final beat of the frame and doubles as the publish strobe.
  always_comb begin
    in_frame = (state == ST_LOCKED) && (slot != '0);
    wr_sel   = frame_sync ? '0 : slot;
    wr_en    = din_valid & (frame_sync | in_frame);
  end

  demux_1x4 u_wr_dec (
    .sel (wr_sel),
    .en  (wr_en),
    .we  (wr_we)
  );

  assign locked = (state == ST_LOCKED);

  // Framing control: state, slot counter, strobes and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      slot        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= wr_we[3];
      sync_err    <= 1'b0;
      if (wr_we[3]) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (din_valid) begin
        if (frame_sync) begin
          // Sync mid-frame abandons the partial frame and restarts at slot 0.
          if (in_frame) begin
            sync_err <= 1'b1;
          end
          state <= ST_LOCKED;
          slot  <= SLOT_W'(1);
        end else if (state == ST_LOCKED) begin
          if (slot == '0) begin
            // Expected a sync beat but did not get one: lose lock.
            sync_err <= 1'b1;
            state    <= ST_HUNT;
          end else begin
            slot <= slot + 1'b1;
          end
        end
      end
    end
  end

  // Shadow capture and atomic publication of a completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
      y0      <= '0;
      y1      <= '0;
      y2      <= '0;
      y3      <= '0;
    end else begin
      if (wr_we[0]) shadow0 <= din;
      if (wr_we[1]) shadow1 <= din;
      if (wr_we[2]) shadow2 <= din;
      if (wr_we[3]) begin
        y0 <= shadow0;
        y1 <= shadow1;
        y2 <= shadow2;
        y3 <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch with a frame-level reference model.
module tb_tdm_demux_4ch;

  localparam int W  = 4;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic [W-1:0]  y0, y1, y2, y3;
  logic          frame_valid, locked, sync_err;
  logic [FW-1:0] frame_cnt;

  tdm_demux_4ch #(.WIDTH(W), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fv   = 0;
  int n_err  = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: a frame is the list of beats since the last sync;
  // four beats make a published frame.
  logic [W-1:0]  ey [4];
  logic          efv, eerr, elock;
  logic [FW-1:0] ecnt;
  logic [W-1:0]  cur [$];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) ey[k] = '0;
      efv = 0; eerr = 0; elock = 0; ecnt = '0;
      cur.delete();
    end else begin
      efv = 0; eerr = 0;
      if (din_valid) begin
        if (frame_sync) begin
          if (elock && cur.size() != 0) eerr = 1;
          cur.delete();
          cur.push_back(din);
          elock = 1;
        end else if (elock) begin
          if (cur.size() == 0) begin
            eerr  = 1;
            elock = 0;
          end else begin
            cur.push_back(din);
            if (cur.size() == 4) begin
              for (int k = 0; k < 4; k++) ey[k] = cur[k];
              efv  = 1;
              ecnt = ecnt + 1'b1;
              cur.delete();
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("y0", y0, ey[0]);
      chk("y1", y1, ey[1]);
      chk("y2", y2, ey[2]);
      chk("y3", y3, ey[3]);
      chk("frame_valid", frame_valid, efv);
      chk("sync_err", sync_err, eerr);
      chk("locked", locked, elock);
      chk("frame_cnt", frame_cnt, ecnt);
      chk("fv_err_exclusive", frame_valid & sync_err, 0);
      if (frame_valid) n_fv++;
      if (sync_err) n_err++;
    end
  end

  // Apply one cycle of inputs; returns #1 after the edge that sampled them.
  task automatic step(input bit v, input bit s, input logic [W-1:0] d);
    din_valid = v; frame_sync = s; din = d;
    @(posedge clk); #1;
    din_valid = 0; frame_sync = 0;
  endtask

  task automatic beat(input bit s, input logic [W-1:0] d);
    step(1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int fv0, err0;

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    armed = 1'b1;
    chk("rst_locked", locked, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_y0", y0, 0);
    rst = 1'b0;

    // 1: single frame A,B,C,D
    beat(1, 4'hA); beat(0, 4'hB); beat(0, 4'hC);
    chk("t1_fv_before", frame_valid, 0);
    beat(0, 4'hD);
    chk("t1_y0", y0, 4'hA); chk("t1_y1", y1, 4'hB);
    chk("t1_y2", y2, 4'hC); chk("t1_y3", y3, 4'hD);
    chk("t1_fv", frame_valid, 1); chk("t1_cnt", frame_cnt, 1);
    chk("t1_locked", locked, 1);
    idle(1);
    chk("t1_fv_pulse", frame_valid, 0);
    chk("t1_y_hold", y3, 4'hD);

    // 2: same frame with 3-cycle gaps
    do_reset();
    beat(1, 4'hA); idle(3); beat(0, 4'hB); idle(3); beat(0, 4'hC); idle(3);
    chk("t2_y0_zero", y0, 0); chk("t2_fv_before", frame_valid, 0);
    beat(0, 4'hD);
    chk("t2_y0", y0, 4'hA); chk("t2_y3", y3, 4'hD); chk("t2_fv", frame_valid, 1);
    idle(2);

    // 3: early sync
    beat(1, 4'd1); beat(0, 4'd2); beat(1, 4'd9);
    chk("t3_err", sync_err, 1); chk("t3_locked", locked, 1);
    beat(0, 4'd8);
    chk("t3_err_pulse", sync_err, 0);
    beat(0, 4'd7); beat(0, 4'd6);
    chk("t3_y0", y0, 9); chk("t3_y1", y1, 8); chk("t3_y2", y2, 7); chk("t3_y3", y3, 6);
    chk("t3_fv", frame_valid, 1); chk("t3_cnt", frame_cnt, 2);

    // 4: missing sync, silent hunt, relock
    beat(1, 4'd1); beat(0, 4'd2); beat(0, 4'd3); beat(0, 4'd4);
    beat(0, 4'd5);
    chk("t4_err", sync_err, 1); chk("t4_unlocked", locked, 0);
    chk("t4_y", y3, 4);
    beat(0, 4'd6); chk("t4_quiet", sync_err, 0);
    beat(0, 4'd7); chk("t4_quiet2", sync_err, 0);
    beat(1, 4'd3); chk("t4_relock", locked, 1); chk("t4_no_err", sync_err, 0);
    beat(0, 4'd1); beat(0, 4'd4); beat(0, 4'd1);
    chk("t4_y0", y0, 3); chk("t4_y3", y3, 1); chk("t4_cnt", frame_cnt, 4);

    // 5: reset mid-frame
    beat(1, 4'hF); beat(0, 4'd1); beat(0, 4'd2);
    do_reset();
    chk("t5_locked", locked, 0); chk("t5_y0", y0, 0); chk("t5_cnt", frame_cnt, 0);
    beat(0, 4'd3);
    chk("t5_ignored", locked, 0); chk("t5_fv", frame_valid, 0); chk("t5_err", sync_err, 0);

    // 6: 256 back-to-back frames, counter wrap
    fv0 = n_fv; err0 = n_err;
    for (int f = 0; f < 256; f++) begin
      beat(1, 4'(f)); beat(0, 4'(f + 1)); beat(0, 4'(f + 2)); beat(0, 4'(f + 3));
      if (f == 254) chk("t6_cnt255", frame_cnt, 255);
    end
    chk("t6_wrap", frame_cnt, 0);
    chk("t6_fv", frame_valid, 1);
    chk("t6_y3", y3, 4'(255 + 3));
    idle(1);
    chk("t6_fv_count", n_fv - fv0, 256);
    chk("t6_err_count", n_err - err0, 0);
    idle(2);

    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive-side counterpart of the 4:1 mux. One serial time-division stream, carrying 4 slots per frame, is split back into 4 parallel channel outputs.
- A slot counter locks to a frame-sync marker and steers each beat into a per-channel shadow register.
- Completed frames are published atomically to the outputs with a one-cycle strobe.
- Sits after the 4:1 TDM mux/link in the gate-level datapath examples.

Parameters:
- WIDTH, 1, data bits per slot (legal range 1 to 32).
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  slot data beat.
- din_valid  input  1  din is valid this cycle. Beats advance only when this is high.
- frame_sync  input  1  qualified by din_valid; marks the current beat as slot 0.
- y0  output  WIDTH  channel 0 (slot 0) data from the last complete frame.
- y1  output  WIDTH  channel 1 (slot 1) data from the last complete frame.
- y2  output  WIDTH  channel 2 (slot 2) data from the last complete frame.
- y3  output  WIDTH  channel 3 (slot 3) data from the last complete frame.
- frame_valid  output  1  one-cycle pulse; y0..y3 were updated this cycle.
- locked  output  1  high in the LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.
- frame_cnt  output  FCNT_W  count of published frames; wraps modulo 2^FCNT_W.

Behaviour:
- Reset (rst=1 at a clk edge):
  - y0..y3 = 0, frame_valid = 0, sync_err = 0, locked = 0, frame_cnt = 0.
  - Slot counter = 0, shadow registers = 0, state = HUNT.
  - Reset mid-frame discards the partial frame; no frame_valid is issued.
- States: HUNT, LOCKED. Encoding is 1 bit.
- HUNT:
  - Beats without frame_sync are ignored silently (no sync_err).
  - A beat with din_valid & frame_sync: shadow0 <= din, slot <= 1, state -> LOCKED.
- LOCKED, per beat (din_valid=1):
  - frame_sync=1 and slot==0: normal slot-0 capture; slot <= 1.
  - frame_sync=1 and slot!=0 (early sync):
    - sync_err pulses next cycle.
    - The partial frame is discarded.
    - The beat is taken as slot 0 of a new frame: shadow0 <= din, slot <= 1. State stays LOCKED.
  - frame_sync=0 and slot==0 (missing sync):
    - sync_err pulses next cycle.
    - The beat is dropped; state -> HUNT.
  - frame_sync=0 and slot in 1..3: shadow[slot] <= din; slot increments.
  - Slot 3 capture: slot wraps to 0. On the next edge:
    - y0..y2 <= shadow0..2 and y3 <= the slot-3 beat, all simultaneously.
    - frame_valid pulses for exactly 1 cycle.
    - frame_cnt increments.
- Latency: frame_valid is high on the cycle after the clk edge that sampled the slot-3 beat.
  - y0..y3 change only on that edge and hold otherwise.
- din_valid=0: no state, slot or shadow change. Gaps of any length inside a frame are legal.
- Back-to-back frames (sync beat directly after a slot-3 beat) are legal. frame_valid and the new slot-0 capture happen in the same cycle.
- frame_cnt wrap: 255 -> 0 at FCNT_W=8, with no flag.
- sync_err and frame_valid are never high in the same cycle. An early sync at slot 3 cannot occur, because that beat is taken as slot 0.
- locked is a registered copy of the state (state == LOCKED).

Decomposition:
- Shared header/package, tdm_defs:
  - State constants ST_HUNT=0, ST_LOCKED=1.
  - SLOTS=4 and SLOT_W=2.
  - The same constants are used by the mux-side TDM transmitter.
- One sub-module, demux_1x4: combinational 2-bit select to one-hot 4-bit write-enable decoder, gated by an enable input. Built in gate-level style; it drives the shadow-register write enables.
- All registers live in tdm_demux_4ch.

Test Plan:
1. Reset, then one frame with WIDTH=4. Beats A(sync), B, C, D on consecutive cycles -> one cycle after D: y0..y3 = A,B,C,D, frame_valid=1 for 1 cycle, frame_cnt=1, locked=1.
2. Gaps: the same frame with din_valid=0 for 3 cycles between each beat -> identical outputs; frame_valid only after D; y0..y3 held at 0 until then.
3. Early sync: 1(sync), 2, then 9(sync), 8, 7, 6 -> sync_err pulse after the 9 beat; the frame 1,2 is never published; y0..y3 = 9,8,7,6 with one frame_valid.
4. Missing sync: a full frame, then a beat 5 without sync -> sync_err pulse, locked=0. Following beats without sync are ignored with no sync_err. The next sync beat relocks.
5. Reset mid-frame: sync, 1, 2, then rst=1 for 1 cycle, then 3 -> all outputs 0, no frame_valid, state HUNT; beat 3 is ignored.
6. Wrap: 256 back-to-back frames with FCNT_W=8 -> frame_cnt reads 0 after the 256th frame_valid; 256 frame_valid pulses and zero sync_err pulses in total.
